// File: rtl/mcs4_bus_initiator.sv
// mcs4_bus_initiator: MCS-4 bus master producing clk1/clk2, SYNC, A1-X3 sequencing and one fetch per host request.
// Define MCS4_IO_CYCLE_EN for the M2 CM strobe, WRR/SRC X2 drive and RDR X2 capture.
module mcs4_bus_initiator #(
    parameter int CLK_DIV = 8
) (
    input  logic        sysclk,
    input  logic        poc_n,
    output logic        clk1,
    output logic        clk2,
    output logic        sync,
    output logic        cmrom,
    input  logic [3:0]  data_in,
    output logic [3:0]  data_out,
    output logic        data_dir,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_pc,
    input  logic [3:0]  req_xdata,
    output logic        rsp_valid,
    output logic [3:0]  rsp_opr,
    output logic [3:0]  rsp_opa,
    output logic [3:0]  rsp_rdata
);
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] T_END = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_Q   = TW'(CLK_DIV / 4);
    localparam logic [TW-1:0] T_H   = TW'(CLK_DIV / 2);
    localparam logic [TW-1:0] T_3Q  = TW'(3 * CLK_DIV / 4);
    localparam logic [TW-1:0] T_CAP = TW'(3 * CLK_DIV / 4 - 1);

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

    phase_t        phase, nph;
    logic [TW-1:0] tick, ntk;
    logic          active, nact, at_end, last;
    logic [11:0]   pc, npc;
    logic [3:0]    xdata, nxd, opr, opa, rdata, n_out;
    logic          io_e, wrr, rdr, src, x2_drv, n_dir, n_cm;

    // Outputs are computed from the next counter state so they register in step with it.
    always_comb begin
        at_end = phase == X3 && tick == T_END;
        ntk    = tick == T_END ? '0 : tick + 1'b1;
        nph    = tick == T_END ? phase_t'(phase + 3'd1) : phase;
        last   = nph == X3 && ntk == T_END;
        nact   = at_end ? req_valid : active;
        npc    = at_end ? req_pc : pc;
        nxd    = at_end ? req_xdata : xdata;
`ifdef MCS4_IO_CYCLE_EN
        io_e   = opr == 4'hE;
        wrr    = io_e && opa == 4'b0010;
        rdr    = io_e && opa == 4'b1010;
        src    = opr == 4'h2 && opa[0];
`else
        io_e   = 1'b0;
        wrr    = 1'b0;
        rdr    = 1'b0;
        src    = 1'b0;
`endif
        x2_drv = nph == X2 && (wrr || src);
        n_dir  = nact && (nph <= A3 || x2_drv);
        n_cm   = nact && (nph == A3 || (nph == M2 && io_e) || (nph == X2 && src));
        n_out  = !nact        ? 4'h0 :
                 nph == A1    ? npc[3:0] :
                 nph == A2    ? npc[7:4] :
                 nph == A3    ? npc[11:8] :
                 x2_drv       ? nxd : 4'h0;
    end

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            phase     <= X2;
            tick      <= T_END;
            active    <= 1'b0;
            pc        <= '0;
            xdata     <= '0;
            opr       <= '0;
            opa       <= '0;
            rdata     <= '0;
            clk1      <= 1'b0;
            clk2      <= 1'b0;
            sync      <= 1'b0;
            cmrom     <= 1'b0;
            data_out  <= '0;
            data_dir  <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_opr   <= '0;
            rsp_opa   <= '0;
            rsp_rdata <= '0;
        end else begin
            phase     <= nph;
            tick      <= ntk;
            active    <= nact;
            pc        <= npc;
            xdata     <= nxd;
            if (phase == M1 && tick == T_CAP) opr <= data_in;
            if (phase == M2 && tick == T_CAP) opa <= data_in;
            if (phase == X2 && tick == T_CAP) rdata <= data_in;
            clk1      <= ntk < T_Q;
            clk2      <= ntk >= T_H && ntk < T_3Q;
            sync      <= nph == X3;
            cmrom     <= n_cm;
            data_out  <= n_out;
            data_dir  <= n_dir;
            req_ready <= last;
            rsp_valid <= last && active;
            if (last && active) begin
                rsp_opr   <= opr;
                rsp_opa   <= opa;
                rsp_rdata <= rdr ? rdata : 4'h0;
            end
        end
    end
endmodule

// File: doc/mcs4_bus_initiator.md
# mcs4_bus_initiator

- Bus-master end of the MCS-4 4-bit multiplexed bus. Generates the two-phase clock, SYNC, the A1–X3 instruction-cycle sequence and CM-ROM strobing, and runs one fetch per request from a host-side valid/ready port.
- Used as the CPU-side bus engine that drives i4001-class ROM/I-O responders in FPGA test systems and in 4004-less configurations.

## Interface
- CLK_DIV, 8: sysclk cycles per subcycle; multiple of 4, ≥8.
- sysclk  in  1  system clock; everything is clocked on its rising edge.
- poc_n  in  1  asynchronous, active-low reset.
- clk1, clk2  out  1  two-phase bus clocks.
- sync  out  1  cycle marker, high for all of X3.
- cmrom  out  1  CM-ROM strobe.
- data_in  in  4  bus data from responders.
- data_out  out  4  bus data driven by the initiator.
- data_dir  out  1  1 = the initiator drives the bus.
- req_valid / req_ready  in / out  1  request handshake.
- req_pc  in  12  fetch address; [11:8] is the ROM chip number.
- req_xdata  in  4  nibble driven in X2 for WRR/SRC.
- rsp_valid  out  1  one-sysclk result pulse.
- rsp_opr, rsp_opa, rsp_rdata  out  4 each  fetched OPR, fetched OPA, RDR read data.

## Operation
- Phase counter cycles A1, A2, A3, M1, M2, X1, X2, X3, then back to A1.
- Tick counter runs 0..CLK_DIV-1 inside each subcycle.
- clk1 is high for ticks [0, D/4). clk2 is high for ticks [D/2, 3D/4). D = CLK_DIV.
- Request transfer: req_valid & req_ready. req_ready is high only on X3, tick D-1.
  - An accepted request makes the next cycle active; otherwise the next cycle is idle.
  - req_pc and req_xdata are latched at the transfer.
- Active cycle:
  - A1 drives pc[3:0], A2 drives pc[7:4], A3 drives pc[11:8]; data_dir=1 for all three.
  - cmrom=1 for all of A3.
  - M1 and M2: data_dir=0. data_in is captured into OPR at M1 and into OPA at M2, on tick 3D/4-1.
  - X1 and X3: data_dir=0, cmrom=0.
- Idle cycle: data_dir=0, cmrom=0, data_out=0 for all eight subcycles. clk1, clk2 and sync keep running. No rsp_valid.
- I/O extension (MCS4_IO_CYCLE_EN):
  - OPR==4'hE: cmrom=1 for all of M2.
  - OPR==4'hE and OPA==4'b0010 (WRR): X2 drives req_xdata with data_dir=1.
  - OPR==4'hE and OPA==4'b1010 (RDR): X2 has data_dir=0, and data_in is captured into rsp_rdata on tick 3D/4-1.
  - OPR==4'h2 and OPA[0]==1 (SRC): X2 drives req_xdata with data_dir=1 and cmrom=1.
- Result: rsp_valid pulses on X3, tick D-1, of each active cycle. rsp_opr, rsp_opa and rsp_rdata hold until the next pulse. rsp_rdata=0 when no RDR was executed.

## Timing
- All outputs are registered.
- data_out, data_dir, cmrom and sync change only at tick 0 of a subcycle. They are stable across clk1 and clk2.
- Instruction cycle length is 8·CLK_DIV sysclk.
- Latency from transfer to rsp_valid is 8·CLK_DIV sysclk. Back-to-back requests sustain one fetch per cycle.
- Reset:
  - While poc_n=0, every output is 0, including req_ready and rsp_*.
  - The counter resets to X2, tick D-1.
  - The first edge after release enters X3, tick 0 (sync=1), so responders see SYNC before the first A1.
  - The first cycle is idle unless req_valid is high at the first req_ready.
- Reset mid-cycle aborts the cycle immediately. The pending response is dropped and never pulsed.
- If req_valid falls between cycles, an idle cycle runs. Requests are never queued.
- rsp_valid and req_ready fall on the same tick, so a host may issue its next request in response to the result.

## Configuration
- MCS4_IO_CYCLE_EN defined: M2 CM strobe, WRR/SRC X2 drive and RDR X2 capture are all active.
- Undefined: fetch-only.
  - cmrom is asserted only in A3.
  - X1–X3 never drive the bus.
  - rsp_rdata is constantly 0.
  - req_xdata is ignored.

## Test plan
- Reset release with CLK_DIV=8 and no request:
  - sync high during sysclk cycles 1–8.
  - clk1 high on ticks 0–1 of each subcycle; clk2 high on ticks 4–5.
  - data_dir and cmrom stay 0.
- Fetch: req_pc=12'h3A5, responder returns 8'h6C.
  - Bus carries 5, A, 3 in A1–A3, with cmrom only in A3.
  - rsp_opr=6, rsp_opa=C.
  - rsp_valid arrives 64 sysclk after the transfer.
- Back-to-back requests at pc 0x000 and 0x001: two consecutive active cycles, two rsp_valid pulses 64 clocks apart, no idle cycle between them.
- (IO_EN) ROM returns 8'hE2 with req_xdata=9: cmrom=1 in M2; X2 drives 9 with data_dir=1.
- (IO_EN) ROM returns 8'hEA, responder drives 7 in X2: rsp_rdata=7 and data_dir=0 in X2.
- Assert poc_n=0 during M1 of an active cycle:
  - All outputs 0 immediately, no rsp_valid.
  - After release, sync is seen before the next A1.
